sol_entry: RTL and testbench
============================

# sol_entry

Player-input front end for the 10-cell puzzle checker. Turns raw pushbuttons into a registered 10-bit candidate solution, counts moves, latches the selected test case, and drives the checker's `en`/`testcase`/`my_sol` inputs. It also captures the checker's combinational verdict into a registered result.

## Interface

Parameters:
- `W`, 10: solution width; one toggle button per cell.
- `CNT_W`, 4: move counter width.
- `MAX_MOVES`, 10: move budget; used only with `MOVE_LIMIT_EN`.

Ports:
- `clk`, input, 1: single clock.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `btn`, input, W: raw asynchronous cell-toggle buttons, active-high.
- `btn_submit`, input, 1: raw submit button.
- `btn_clear`, input, 1: raw clear/new-round button.
- `testcase_sel`, input, 2: slide switches for the puzzle number.
- `is_correct`, input, 1: checker verdict, combinational.
- `is_finish`, input, 1: checker finish flag, combinational.
- `my_sol`, output, W: candidate solution to the checker.
- `testcase`, output, 2: latched puzzle number to the checker.
- `en`, output, 1: checker enable.
- `move_cnt`, output, CNT_W: toggles accepted this round.
- `result_valid`, output, 1: verdict captured.
- `result_ok`, output, 1: captured verdict was correct.
- `limit_hit`, output, 1: move budget exhausted.

## Operation

- Every raw button passes through a 2-flop synchronizer and a rising-edge detector, giving a one-cycle pulse per press. No debounce is done here; the board-level input filter handles it.
- FSM states:
  - `EDIT`: toggles and clear are live.
  - `CHECK`: one cycle in which `en`=1 and the verdict is captured.
  - `DONE`: holds the verdict.
- Reset state: `EDIT`.
- Behaviour in `EDIT`, in priority order:
  - clear pulse: `my_sol`←0, `move_cnt`←0, `testcase`←`testcase_sel`, `limit_hit`←0.
  - else submit pulse: go to `CHECK`. Toggle pulses arriving in the same cycle are discarded.
  - else each toggle pulse flips `my_sol[i]`. Several pulses in one cycle all apply.
- Move counting: `move_cnt` increases by the popcount of accepted pulses and saturates at 2^CNT_W−1.
- `CHECK`: `en`=1, `my_sol` and `testcase` frozen. Capture `result_ok`←`is_correct` and set `result_valid`←1. If `is_finish`=0, which is unreachable with the current checker, capture `result_ok`←0. Go to `DONE`.
- `DONE`:
  - `en` stays 1 so the checker's outputs remain displayable.
  - Toggle and submit pulses are ignored.
  - A clear pulse performs the clear action, drops `result_valid`/`result_ok`, and goes to `EDIT`.
- `en` is 0 in `EDIT`.
- Reset, including reset asserted mid-round:
  - all synchronizer/edge flops 0
  - `my_sol`=0, `testcase`=0, `en`=0, `move_cnt`=0
  - `result_valid`=0, `result_ok`=0, `limit_hit`=0
  - state `EDIT`

## Timing

- Raw rise to toggle visible on `my_sol`: 3 cycles (2 sync flops, edge register, state update).
- Submit raw rise to `en`=1: 3 cycles. `result_valid` and `result_ok` rise 1 cycle later.
- A button held high produces exactly one pulse. Re-pressing requires the synchronized input to be low for at least 1 cycle.
- All outputs are registered. None depend combinationally on any input.

## Configuration

- `MOVE_LIMIT_EN` defined:
  - in `EDIT`, when `move_cnt`≥`MAX_MOVES`, toggle pulses are ignored and `limit_hit`=1.
  - if a multi-pulse cycle would exceed the budget, the whole cycle's pulses are dropped.
  - submit and clear still work.
- `MOVE_LIMIT_EN` undefined: no budget, `limit_hit` tied to 0, and `MAX_MOVES` is unused.

## Structure

- Shared package `puzzle_pkg` holds:
  - state enum (`EDIT`, `CHECK`, `DONE`)
  - `SOL_W`=10
  - testcase width constant 2
- Sub-module `btn_edge` (synchronizer plus rising-edge pulse), instantiated W+2 times, width-parameterized.

## Test plan

- Reset mid-round with `my_sol`=10'h2A5 and `move_cnt`=5 → all outputs 0 asynchronously, state `EDIT`.
- Clear with `testcase_sel`=3, then press cells 2, 7, 9, then submit → `my_sol`=10'h284, `move_cnt`=3, `en`=1, `result_ok`=1.
- `testcase`=2, press cells 0 and 5 only, then submit → `result_valid`=1, `result_ok`=0.
- Press cells 1 and 4 in the same cycle, then cell 1 again → `my_sol`=10'h010, `move_cnt`=3.
- Submit and cell 3 in the same cycle → cell 3 unchanged. Toggles in `DONE` are ignored. Clear returns to `EDIT` with `en`=0.
- With `MOVE_LIMIT_EN` and `MAX_MOVES`=10, apply 12 presses → `move_cnt`=10, `limit_hit`=1, last two presses not applied. Without the macro → `move_cnt`=12, `limit_hit`=0.

Source files
------------

// File: rtl/puzzle_pkg.sv
// Shared types and widths for the 10-cell puzzle front end and checker.
package puzzle_pkg;

  localparam int SOL_W = 10;
  localparam int TC_W  = 2;

  typedef enum logic [1:0] {
    EDIT  = 2'd0,
    CHECK = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/btn_edge.sv
// Two-flop synchronizer followed by a rising-edge detector; one pulse per press.
module btn_edge #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] pulse
);

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] prev_q, prev_d;

  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign pulse = sync2_q & ~prev_q;

endmodule

// File: rtl/sol_entry.sv
// Player-input front end: button pulses -> registered candidate solution, move
// count, latched testcase and checker enable. Optional move budget: MOVE_LIMIT_EN.
module sol_entry
  import puzzle_pkg::*;
#(
  parameter int W         = SOL_W,
  parameter int CNT_W     = 4,
  parameter int MAX_MOVES = 10
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [W-1:0]    btn,
  input  logic            btn_submit,
  input  logic            btn_clear,
  input  logic [TC_W-1:0] testcase_sel,
  input  logic            is_correct,
  input  logic            is_finish,
  output logic [W-1:0]    my_sol,
  output logic [TC_W-1:0] testcase,
  output logic            en,
  output logic [CNT_W-1:0] move_cnt,
  output logic            result_valid,
  output logic            result_ok,
  output logic            limit_hit
);

`ifdef MOVE_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  localparam int          NB      = W + 2;
  localparam logic [31:0] CNT_MAX = 32'((2 ** CNT_W) - 1);
  localparam logic [31:0] BUDGET  = 32'(MAX_MOVES);

  logic [NB-1:0] raw_all;
  logic [NB-1:0] pulse_all;
  logic [W-1:0]  tgl_p;
  logic          submit_p;
  logic          clear_p;

  assign raw_all = {btn_clear, btn_submit, btn};

  for (genvar g = 0; g < NB; g++) begin : g_edge
    btn_edge #(.WIDTH(1)) u_edge (
      .clk     (clk),
      .reset_n (reset_n),
      .raw     (raw_all[g]),
      .pulse   (pulse_all[g])
    );
  end

  assign tgl_p    = pulse_all[W-1:0];
  assign submit_p = pulse_all[W];
  assign clear_p  = pulse_all[W+1];

  state_e          state_q, state_d;
  logic [W-1:0]    my_sol_q, my_sol_d;
  logic [TC_W-1:0] testcase_q, testcase_d;
  logic            en_q, en_d;
  logic [CNT_W-1:0] move_cnt_q, move_cnt_d;
  logic            result_valid_q, result_valid_d;
  logic            result_ok_q, result_ok_d;
  logic            limit_hit_q, limit_hit_d;

  logic [31:0] cnt_sum;
  logic        tgl_ok;

  assign cnt_sum = 32'(move_cnt_q) + 32'($countones(tgl_p));
  // A multi-pulse cycle that would overrun the budget is dropped as a whole.
  assign tgl_ok  = !LIMIT_EN || (cnt_sum <= BUDGET);

  // NOTE: every _d gets its hold value first, so no path through the case
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d        = state_q;
    my_sol_d       = my_sol_q;
    testcase_d     = testcase_q;
    move_cnt_d     = move_cnt_q;
    result_valid_d = result_valid_q;
    result_ok_d    = result_ok_q;

    unique case (state_q)
      EDIT: begin
        if (clear_p) begin
          my_sol_d   = '0;
          move_cnt_d = '0;
          testcase_d = testcase_sel;
        end else if (submit_p) begin
          state_d = CHECK;
        end else if (tgl_ok) begin
          my_sol_d   = my_sol_q ^ tgl_p;
          move_cnt_d = (cnt_sum > CNT_MAX) ? CNT_W'(CNT_MAX) : CNT_W'(cnt_sum);
        end
      end
      CHECK: begin
        // An unfinished checker never counts as a correct verdict.
        result_ok_d    = is_correct && is_finish;
        result_valid_d = 1'b1;
        state_d        = DONE;
      end
      DONE: begin
        if (clear_p) begin
          my_sol_d       = '0;
          move_cnt_d     = '0;
          testcase_d     = testcase_sel;
          result_valid_d = 1'b0;
          result_ok_d    = 1'b0;
          state_d        = EDIT;
        end
      end
      default: state_d = EDIT;
    endcase

    en_d        = (state_d != EDIT);
    limit_hit_d = LIMIT_EN && (32'(move_cnt_d) >= BUDGET);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= EDIT;
      my_sol_q       <= '0;
      testcase_q     <= '0;
      en_q           <= 1'b0;
      move_cnt_q     <= '0;
      result_valid_q <= 1'b0;
      result_ok_q    <= 1'b0;
      limit_hit_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      my_sol_q       <= my_sol_d;
      testcase_q     <= testcase_d;
      en_q           <= en_d;
      move_cnt_q     <= move_cnt_d;
      result_valid_q <= result_valid_d;
      result_ok_q    <= result_ok_d;
      limit_hit_q    <= limit_hit_d;
    end
  end

  assign my_sol       = my_sol_q;
  assign testcase     = testcase_q;
  assign en           = en_q;
  assign move_cnt     = move_cnt_q;
  assign result_valid = result_valid_q;
  assign result_ok    = result_ok_q;
  assign limit_hit    = limit_hit_q;

endmodule

// File: tb/tb_sol_entry.sv
// Scoreboard bench for sol_entry: event-level model pushes expected verdicts,
// a negedge monitor pops them whenever result_valid rises.
module tb_sol_entry;

  localparam int W         = 10;
  localparam int CNT_W     = 4;
  localparam int MAX_MOVES = 10;
  localparam int CNT_SAT   = 15;

`ifdef MOVE_LIMIT_EN
  localparam bit LIM = 1'b1;
`else
  localparam bit LIM = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [W-1:0]     btn = '0;
  logic             btn_submit = 1'b0;
  logic             btn_clear = 1'b0;
  logic [1:0]       testcase_sel = '0;
  logic             is_correct;
  logic             is_finish;
  logic             finish_drv = 1'b1;
  logic [W-1:0]     my_sol;
  logic [1:0]       testcase;
  logic             en;
  logic [CNT_W-1:0] move_cnt;
  logic             result_valid;
  logic             result_ok;
  logic             limit_hit;

  int n_checks = 0;
  int n_fail   = 0;

  sol_entry #(.W(W), .CNT_W(CNT_W), .MAX_MOVES(MAX_MOVES)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .btn          (btn),
    .btn_submit   (btn_submit),
    .btn_clear    (btn_clear),
    .testcase_sel (testcase_sel),
    .is_correct   (is_correct),
    .is_finish    (is_finish),
    .my_sol       (my_sol),
    .testcase     (testcase),
    .en           (en),
    .move_cnt     (move_cnt),
    .result_valid (result_valid),
    .result_ok    (result_ok),
    .limit_hit    (limit_hit)
  );

  always #5 clk = ~clk;

  // Stand-in checker: one known answer per puzzle.
  function automatic logic [W-1:0] golden(input logic [1:0] tc);
    case (tc)
      2'd0:    return 10'h155;
      2'd1:    return 10'h0F0;
      2'd2:    return 10'h0A1;
      default: return 10'h284;
    endcase
  endfunction

  assign is_correct = (my_sol == golden(testcase));
  assign is_finish  = finish_drv;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [W-1:0] sol;
    logic [1:0]   tc;
    logic         ok;
    int           cnt;
    logic         lim;
  } exp_t;

  exp_t sb_q[$];

  logic [W-1:0] m_sol  = '0;
  logic [1:0]   m_tc   = '0;
  int           m_cnt  = 0;
  bit           m_done = 1'b0;

  function automatic logic m_limit();
    return LIM && (m_cnt >= MAX_MOVES);
  endfunction

  // Apply one button event to the player-level model of the round.
  task automatic model_event(input logic [W-1:0] t, input bit sub, input bit clr);
    exp_t e;
    int   pop;
    if (clr) begin
      m_sol  = '0;
      m_cnt  = 0;
      m_tc   = testcase_sel;
      m_done = 1'b0;
    end else if (!m_done) begin
      if (sub) begin
        m_done = 1'b1;
        e.sol  = m_sol;
        e.tc   = m_tc;
        e.ok   = finish_drv && (m_sol == golden(m_tc));
        e.cnt  = m_cnt;
        e.lim  = m_limit();
        sb_q.push_back(e);
      end else begin
        pop = $countones(t);
        if (!LIM || (m_cnt + pop <= MAX_MOVES)) begin
          m_sol = m_sol ^ t;
          m_cnt = (m_cnt + pop > CNT_SAT) ? CNT_SAT : m_cnt + pop;
        end
      end
    end
  endtask

  task automatic press(input logic [W-1:0] t, input bit sub, input bit clr);
    model_event(t, sub, clr);
    @(negedge clk);
    btn = t; btn_submit = sub; btn_clear = clr;
    @(negedge clk);
    btn = '0; btn_submit = 1'b0; btn_clear = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic clear_round(input logic [1:0] sel);
    testcase_sel = sel;
    press('0, 1'b0, 1'b1);
  endtask

  task automatic check_state(input string tag);
    check({tag, "_my_sol"},   my_sol,       m_sol);
    check({tag, "_move_cnt"}, move_cnt,     m_cnt);
    check({tag, "_testcase"}, testcase,     m_tc);
    check({tag, "_en"},       en,           m_done);
    check({tag, "_rvalid"},   result_valid, m_done);
    check({tag, "_limit"},    limit_hit,    m_limit());
  endtask

  // Monitor: every rising result_valid must match the oldest expected verdict.
  logic rv_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (result_valid && !rv_prev) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_result", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("sb_my_sol",   my_sol,    e.sol);
        check("sb_testcase", testcase,  e.tc);
        check("sb_result",   result_ok, e.ok);
        check("sb_move_cnt", move_cnt,  e.cnt);
        check("sb_limit",    limit_hit, e.lim);
        check("sb_en",       en,        1'b1);
      end
    end
    rv_prev = result_valid;
  end

  initial begin
    logic [W-1:0] t;
    int           nmv;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_my_sol", my_sol, 0);
    check("rst_en", en, 0);
    check("rst_rvalid", result_valid, 0);
    check("rst_cnt", move_cnt, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Puzzle 3: cells 2,7,9 then submit, with exact latency of en/result
    clear_round(2'd3);
    press(10'h004, 1'b0, 1'b0);
    press(10'h080, 1'b0, 1'b0);
    press(10'h200, 1'b0, 1'b0);
    check("tc3_sol", my_sol, 10'h284);
    check("tc3_cnt", move_cnt, 3);
    model_event('0, 1'b1, 1'b0);
    @(negedge clk); btn_submit = 1'b1;
    @(negedge clk); btn_submit = 1'b0;
    @(posedge clk); #1 check("lat_en_early", en, 0);
    @(posedge clk); #1 check("lat_en", en, 1);
    check("lat_rvalid_early", result_valid, 0);
    @(posedge clk); #1 check("lat_rvalid", result_valid, 1);
    check("tc3_ok", result_ok, 1);
    repeat (3) @(negedge clk);
    check_state("tc3");

    // Puzzle 2: wrong answer
    clear_round(2'd2);
    press(10'h001, 1'b0, 1'b0);
    press(10'h020, 1'b0, 1'b0);
    press('0, 1'b1, 1'b0);
    check("tc2_ok", result_ok, 0);
    check_state("tc2");

    // Simultaneous presses, then re-press
    clear_round(2'd1);
    press(10'h012, 1'b0, 1'b0);
    press(10'h002, 1'b0, 1'b0);
    check("multi_sol", my_sol, 10'h010);
    check("multi_cnt", move_cnt, 3);

    // Submit wins over a same-cycle toggle; DONE ignores toggles and submit
    press(10'h008, 1'b1, 1'b0);
    check("sub_tgl_cell3", my_sol[3], 0);
    press(10'h3FF, 1'b0, 1'b0);
    press('0, 1'b1, 1'b0);
    check_state("done_hold");
    clear_round(2'd0);
    check("clear_en", en, 0);
    check_state("after_clear");

    // Move budget: 12 single presses
    clear_round(2'd1);
    for (int i = 0; i < 12; i++) press(W'(1) << (i % 10), 1'b0, 1'b0);
    check("budget_cnt", move_cnt, LIM ? 10 : 12);
    check("budget_limit", limit_hit, LIM);
    check_state("budget");
    press('0, 1'b1, 1'b0);

    // Multi-pulse overrun / counter saturation
    clear_round(2'd0);
    press(10'h3FF, 1'b0, 1'b0);
    press(10'h3FF, 1'b0, 1'b0);
    check("sat_cnt", move_cnt, LIM ? 10 : 15);
    check_state("sat");

    // Unfinished checker verdict is captured as not-ok
    clear_round(2'd3);
    press(10'h284, 1'b0, 1'b0);
    finish_drv = 1'b0;
    press('0, 1'b1, 1'b0);
    check("unfinished_ok", result_ok, 0);
    finish_drv = 1'b1;

    // Randomized rounds
    for (int r = 0; r < 30; r++) begin
      finish_drv = ($urandom_range(0, 7) != 0);
      clear_round(2'($urandom_range(0, 3)));
      nmv = $urandom_range(0, 8);
      for (int k = 0; k < nmv; k++) begin
        if ($urandom_range(0, 3) == 0) t = m_sol ^ golden(m_tc);
        else t = W'($urandom & $urandom);
        press(t, 1'b0, 1'b0);
      end
      if ($urandom_range(0, 2) == 0) t = W'($urandom);
      else t = '0;
      press(t, 1'b1, 1'b0);
      if ($urandom_range(0, 1) == 0) press(W'($urandom), 1'b0, 1'b0);
      check_state("rand");
    end
    finish_drv = 1'b1;

    // Asynchronous reset mid-round
    clear_round(2'd2);
    press(10'h2A5, 1'b0, 1'b0);
    check("mid_sol", my_sol, 10'h2A5);
    check("mid_cnt", move_cnt, 5);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("arst_sol", my_sol, 0);
    check("arst_cnt", move_cnt, 0);
    check("arst_tc", testcase, 0);
    check("arst_en", en, 0);
    check("arst_rvalid", result_valid, 0);
    check("arst_ok", result_ok, 0);
    check("arst_limit", limit_hit, 0);
    m_sol = '0; m_cnt = 0; m_tc = '0; m_done = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    press(10'h001, 1'b0, 1'b0);
    check_state("post_rst");

    check("sb_drain", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
